// File: rtl/mode_pkg.sv
// Shared speed-mode encoding and scheduler state types for the game timing blocks.
// The mode FSM and the tick scheduler both import this package.
package mode_pkg;

  typedef enum logic [1:0] {
    SLOW   = 2'd0,
    FAST   = 2'd1,
    TURTLE = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } sched_state_t;

  localparam int OVR_W = 8;

  // The unused encoding 2'b11 falls back to SLOW so the game never stalls on a bad mode.
  function automatic mode_t norm_mode(input logic [1:0] raw);
    mode_t m;
    case (raw)
      2'd1:    m = FAST;
      2'd2:    m = TURTLE;
      default: m = SLOW;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/game_tick_sched_tick_counter.sv
// Period counter for the tick scheduler: counts up while enabled and wraps on div-1.
// The divisor is held internally and only changes when load_i is asserted.
module tick_counter #(
  parameter int          CNT_W   = 24,
  parameter int unsigned RST_DIV = 5_000_000
) (
  input  logic             clk_i,
  input  logic             nrst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W:0]   div_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   div_q, div_d;
  logic [CNT_W:0]   div_m1;

  // The divisor may equal 2^CNT_W, so it carries one extra bit over the count.
  assign div_m1 = div_q - (CNT_W+1)'(1);
  assign tc_o   = en_i && ({1'b0, cnt_q} == div_m1);

  always_comb begin
    cnt_d = cnt_q;
    div_d = div_q;
    if (clr_i || tc_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load_i) begin
      div_d = div_i;
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt_q <= '0;
      div_q <= (CNT_W+1)'(RST_DIV);
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/game_tick_sched.sv
// Game tick scheduler: issues a step request once per mode-dependent period, with a
// req/ack handshake toward the game logic and a saturating count of lost steps.
module game_tick_sched
  import mode_pkg::*;
#(
  parameter int unsigned SLOW_DIV   = 5_000_000,
  parameter int unsigned FAST_DIV   = 2_500_000,
  parameter int unsigned TURTLE_DIV = 10_000_000,
  parameter int          CNT_W      = 24
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [1:0] mode,
  input  logic       run,
  input  logic       step_ack,
  output logic       step_req,
  output logic [1:0] step_mode,
  output logic [7:0] overrun_cnt,
  input  logic       clear_ovr,
  output logic       busy
);

  localparam int DW = CNT_W + 1;

  sched_state_t     state_q, state_d;
  mode_t            per_mode_q, per_mode_d;
  mode_t            step_mode_q, step_mode_d;
  mode_t            cur_mode;
  logic             step_req_q, step_req_d;
  logic [OVR_W-1:0] ovr_q, ovr_d;
  logic [DW-1:0]    sel_div;
  logic             cnt_clr, cnt_en, cnt_load, tc, step_evt;

  assign cur_mode = norm_mode(mode);

  always_comb begin
    case (cur_mode)
      FAST:    sel_div = DW'(FAST_DIV);
      TURTLE:  sel_div = DW'(TURTLE_DIV);
      default: sel_div = DW'(SLOW_DIV);
    endcase
  end

  tick_counter #(
    .CNT_W   (CNT_W),
    .RST_DIV (SLOW_DIV)
  ) u_tick_counter (
    .clk_i  (clk),
    .nrst_i (nrst),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .load_i (cnt_load),
    .div_i  (sel_div),
    .tc_o   (tc)
  );

  always_comb begin
    state_d     = state_q;
    per_mode_d  = per_mode_q;
    step_req_d  = step_req_q;
    step_mode_d = step_mode_q;
    ovr_d       = ovr_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    cnt_load    = 1'b0;
    step_evt    = 1'b0;

    // Divider and reported mode are re-latched only on a period boundary.
    if (state_q == RUN) begin
      cnt_en   = 1'b1;
      step_evt = tc;
      if (tc) begin
        cnt_load   = 1'b1;
        per_mode_d = cur_mode;
      end
    end

    if (step_evt) begin
      if (!step_req_q || step_ack) begin
        step_req_d  = 1'b1;
        step_mode_d = per_mode_q;
      end else if (ovr_q != '1) begin
        ovr_d = ovr_q + OVR_W'(1);
      end
    end else if (step_req_q && step_ack) begin
      step_req_d = 1'b0;
    end

    if (clear_ovr) begin
      ovr_d = '0;
    end

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (run) begin
          state_d    = RUN;
          cnt_load   = 1'b1;
          per_mode_d = cur_mode;
        end
      end
      RUN: begin
        // Drain only if a request will still be pending, so an ack taken this cycle cannot strand us.
        if (!run) begin
          cnt_clr = 1'b1;
          state_d = step_req_d ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        cnt_clr = 1'b1;
        if (step_req_q && step_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      per_mode_q  <= SLOW;
      step_mode_q <= SLOW;
      step_req_q  <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      per_mode_q  <= per_mode_d;
      step_mode_q <= step_mode_d;
      step_req_q  <= step_req_d;
      ovr_q       <= ovr_d;
    end
  end

  assign step_req    = step_req_q;
  assign step_mode   = step_mode_q;
  assign overrun_cnt = ovr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_game_tick_sched.sv
// Self-checking bench for game_tick_sched with small dividers (SLOW=4, FAST=2, TURTLE=8).
// Step-request rising edges are matched against a scoreboard of expected cycles and modes.
module tb_game_tick_sched;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       run = 1'b0;
  logic       man_ack = 1'b0;
  logic       auto_ack = 1'b0;
  logic       clear_ovr = 1'b0;
  logic       mon_en = 1'b0;
  logic       prev_req = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       step_ack;
  logic       step_req;
  logic       busy;
  logic [1:0] step_mode;
  logic [7:0] overrun_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int cyc;
    int md;
    bit chk;
  } exp_t;

  typedef struct {
    logic [1:0] mode;
    int         div;
    bit         chk;
    int         md;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];

  // Auto-ack answers every request during the cycle right after it rises.
  assign step_ack = man_ack | (auto_ack & step_req);

  game_tick_sched #(
    .SLOW_DIV   (4),
    .FAST_DIV   (2),
    .TURTLE_DIV (8),
    .CNT_W      (24)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .mode        (mode),
    .run         (run),
    .step_ack    (step_ack),
    .step_req    (step_req),
    .step_mode   (step_mode),
    .overrun_cnt (overrun_cnt),
    .clear_ovr   (clear_ovr),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && step_req && !prev_req) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_req_rise", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("req_rise_cycle", cyc, e.cyc);
        if (e.chk) checkOutput("req_rise_mode", int'(step_mode), e.md);
      end
    end
    prev_req = step_req;
  end

  task automatic applyReset();
    @(negedge clk);
    nrst = 1'b0;
    run = 1'b0;
    man_ack = 1'b0;
    auto_ack = 1'b0;
    clear_ovr = 1'b0;
    mon_en = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic waitScoreboard(input string nm);
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checkOutput({nm, "_timeout"}, sb.size(), 0);
      sb.delete();
    end
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    int c0;
    applyReset();
    mode = v.mode;
    auto_ack = 1'b1;
    mon_en = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 3; k++) sb.push_back('{c0 + v.div + 1 + k * v.div, v.md, v.chk});
    run = 1'b1;
    waitScoreboard("rate");
    checkOutput("rate_busy", int'(busy), 1);
    checkOutput("rate_overrun", int'(overrun_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    int lows;

    vecs[0] = '{2'd0, 4, 1'b1, 0};
    vecs[1] = '{2'd1, 2, 1'b1, 1};
    vecs[2] = '{2'd2, 8, 1'b1, 2};
    vecs[3] = '{2'd3, 4, 1'b0, 0};

    // Reset state.
    #3;
    checkOutput("rst_req", int'(step_req), 0);
    checkOutput("rst_mode", int'(step_mode), 0);
    checkOutput("rst_overrun", int'(overrun_cnt), 0);
    checkOutput("rst_busy", int'(busy), 0);

    // Basic rate in every mode.
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Mode change mid-period only takes effect at the boundary.
    applyReset();
    mode = 2'd0;
    auto_ack = 1'b1;
    mon_en = 1'b1;
    c0 = cyc;
    sb.push_back('{c0 + 5, 0, 1'b1});
    sb.push_back('{c0 + 7, 1, 1'b1});
    sb.push_back('{c0 + 9, 1, 1'b1});
    run = 1'b1;
    repeat (2) @(negedge clk);
    mode = 2'd1;
    waitScoreboard("modechg");

    // Overrun counting, saturation and clear.
    applyReset();
    mode = 2'd1;
    c0 = cyc;
    run = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("ovr_req_held", int'(step_req), 1);
    checkOutput("ovr_count2", int'(overrun_cnt), 2);
    checkOutput("ovr_mode", int'(step_mode), 1);
    repeat (600) @(negedge clk);
    checkOutput("ovr_saturate", int'(overrun_cnt), 255);
    @(negedge clk);
    clear_ovr = 1'b1;
    @(negedge clk);
    clear_ovr = 1'b0;
    checkOutput("ovr_clear_on_tc", int'(overrun_cnt), 0);
    repeat (2) @(negedge clk);
    checkOutput("ovr_after_clear", int'(overrun_cnt), 1);

    // Ack coincident with a step event keeps req high and updates the mode.
    applyReset();
    mode = 2'd1;
    c0 = cyc;
    run = 1'b1;
    @(negedge clk);
    mode = 2'd2;
    repeat (2) @(negedge clk);
    checkOutput("coin_first_req", int'(step_req), 1);
    checkOutput("coin_first_mode", int'(step_mode), 1);
    lows = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (!step_req) lows++;
    end
    checkOutput("coin_old_mode", int'(step_mode), 1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    if (!step_req) lows++;
    checkOutput("coin_new_mode", int'(step_mode), 2);
    checkOutput("coin_no_overrun", int'(overrun_cnt), 0);
    @(negedge clk);
    if (!step_req) lows++;
    checkOutput("coin_no_gap", lows, 0);

    // Stop with a pending request drains, then returns to idle on ack.
    applyReset();
    mode = 2'd1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("drain_req_up", int'(step_req), 1);
    run = 1'b0;
    @(negedge clk);
    checkOutput("drain_busy", int'(busy), 1);
    repeat (4) @(negedge clk);
    checkOutput("drain_req_held", int'(step_req), 1);
    checkOutput("drain_no_steps", int'(overrun_cnt), 0);
    checkOutput("drain_still_busy", int'(busy), 1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    checkOutput("drain_idle", int'(busy), 0);
    checkOutput("drain_req_low", int'(step_req), 0);
    run = 1'b1;
    @(negedge clk);
    checkOutput("stop_run_busy", int'(busy), 1);
    run = 1'b0;
    @(negedge clk);
    checkOutput("stop_idle", int'(busy), 0);
    checkOutput("stop_req_low", int'(step_req), 0);

    // Asynchronous reset while a request and an overrun are pending.
    applyReset();
    mode = 2'd1;
    run = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("areset_pre_req", int'(step_req), 1);
    checkOutput("areset_pre_ovr", int'(overrun_cnt), 1);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("areset_req", int'(step_req), 0);
    checkOutput("areset_mode", int'(step_mode), 0);
    checkOutput("areset_ovr", int'(overrun_cnt), 0);
    checkOutput("areset_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    mode = 2'd3;
    auto_ack = 1'b1;
    mon_en = 1'b1;
    c0 = cyc;
    sb.push_back('{c0 + 5, 0, 1'b0});
    sb.push_back('{c0 + 9, 0, 1'b0});
    sb.push_back('{c0 + 13, 0, 1'b0});
    waitScoreboard("after_reset");
    applyReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
